// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS EX-stage ALU with registered outputs.
// Single-cycle ops (ADD/SUB/OR/XOR/NOR/AND/SLL/SLT, illegal) complete at the
// accepting edge; MULU (shift-add) and DIVU (restoring) take WIDTH cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request, sampled only while busy=0
//   ALU_Control           opcode, sampled with start
//   input_A, input_B      operands, sampled with start
//   Result, Result_Hi     main result / MULU high word or DIVU remainder
//   Zero                  Result==0
//   Overflow              signed overflow for ADD/SUB
//   DivZero               DIVU with zero divisor
//   Illegal               undefined opcode
//   busy                  multi-cycle op in progress
//   done                  one-cycle pulse when outputs are updated
module alu_mc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_Hi,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero,
    output logic             Illegal,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] a_q, a_nx;     // multiplicand / dividend copy
    logic [WIDTH-1:0] b_q, b_nx;     // divisor
    logic [WIDTH-1:0] hi_q, hi_nx;   // product high / partial remainder
    logic [WIDTH-1:0] lo_q, lo_nx;   // multiplier bits / quotient bits

    logic [WIDTH-1:0] res_nx, res_hi_nx;
    logic             zero_nx, ovf_nx, dz_nx, ill_nx, busy_nx, done_nx;

    // Single-cycle datapath.
    logic [WIDTH-1:0] alu_r;
    logic             alu_ov;
    logic             alu_legal;

    always_comb begin
        alu_r     = '0;
        alu_ov    = 1'b0;
        alu_legal = 1'b1;
        case (ALU_Control)
            OP_ADD: begin
                alu_r  = input_A + input_B;
                alu_ov = (input_A[WIDTH-1] == input_B[WIDTH-1]) &&
                         (alu_r[WIDTH-1] != input_A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r  = input_A - input_B;
                alu_ov = (input_A[WIDTH-1] != input_B[WIDTH-1]) &&
                         (alu_r[WIDTH-1] != input_A[WIDTH-1]);
            end
            OP_OR:   alu_r = input_A | input_B;
            OP_XOR:  alu_r = input_A ^ input_B;
            OP_NOR:  alu_r = ~(input_A | input_B);
            OP_AND:  alu_r = input_A & input_B;
            OP_SLL:  alu_r = input_A << input_B[SH_W-1:0];
            OP_SLT:  alu_r = WIDTH'($signed(input_A) < $signed(input_B));
            default: alu_legal = 1'b0;
        endcase
    end

    // One shift-add multiply step: add multiplicand on LSB, shift {hi,lo} right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // One restoring divide step: shift in next dividend bit, subtract if it fits.
    logic [WIDTH:0]   div_shift, div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, div_quo;
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_sub   = div_shift - {1'b0, b_q};
    assign div_rem   = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo   = {lo_q[WIDTH-2:0], div_ge};

    // Next-state and next-output logic.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        a_nx      = a_q;
        b_nx      = b_q;
        hi_nx     = hi_q;
        lo_nx     = lo_q;
        res_nx    = Result;
        res_hi_nx = Result_Hi;
        zero_nx   = Zero;
        ovf_nx    = Overflow;
        dz_nx     = DivZero;
        ill_nx    = Illegal;
        done_nx   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (ALU_Control == OP_MULU) begin
                        state_nx = S_MUL;
                        cnt_nx   = CNT_W'(WIDTH);
                        a_nx     = input_A;
                        hi_nx    = '0;
                        lo_nx    = input_B;
                    end else if (ALU_Control == OP_DIVU) begin
                        state_nx = S_DIV;
                        cnt_nx   = CNT_W'(WIDTH);
                        a_nx     = input_A;
                        b_nx     = input_B;
                        hi_nx    = '0;
                        lo_nx    = input_A;
                    end else begin
                        res_nx    = alu_r;
                        res_hi_nx = '0;
                        zero_nx   = (alu_r == '0);
                        ovf_nx    = alu_ov;
                        dz_nx     = 1'b0;
                        ill_nx    = ~alu_legal;
                        done_nx   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                hi_nx  = mul_hi;
                lo_nx  = mul_lo;
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx  = S_IDLE;
                    res_nx    = mul_lo;
                    res_hi_nx = mul_hi;
                    zero_nx   = (mul_lo == '0);
                    ovf_nx    = 1'b0;
                    dz_nx     = 1'b0;
                    ill_nx    = 1'b0;
                    done_nx   = 1'b1;
                end
            end
            S_DIV: begin
                hi_nx  = div_rem;
                lo_nx  = div_quo;
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = S_IDLE;
                    ovf_nx   = 1'b0;
                    ill_nx   = 1'b0;
                    done_nx  = 1'b1;
                    if (b_q == '0) begin
                        res_nx    = '1;
                        res_hi_nx = a_q;
                        zero_nx   = 1'b0;
                        dz_nx     = 1'b1;
                    end else begin
                        res_nx    = div_quo;
                        res_hi_nx = div_rem;
                        zero_nx   = (div_quo == '0);
                        dz_nx     = 1'b0;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            Result    <= '0;
            Result_Hi <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            DivZero   <= 1'b0;
            Illegal   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            a_q       <= a_nx;
            b_q       <= b_nx;
            hi_q      <= hi_nx;
            lo_q      <= lo_nx;
            Result    <= res_nx;
            Result_Hi <= res_hi_nx;
            Zero      <= zero_nx;
            Overflow  <= ovf_nx;
            DivZero   <= dz_nx;
            Illegal   <= ill_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=16).
module tb_alu_mc;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   ALU_Control;
    logic [W-1:0] input_A;
    logic [W-1:0] input_B;
    logic [W-1:0] Result;
    logic [W-1:0] Result_Hi;
    logic         Zero;
    logic         Overflow;
    logic         DivZero;
    logic         Illegal;
    logic         busy;
    logic         done;

    int n_asrt = 0;
    int n_fail = 0;
    int n_done = 0;

    alu_mc #(.WIDTH(W), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ALU_Control(ALU_Control),
        .input_A    (input_A),
        .input_B    (input_B),
        .Result     (Result),
        .Result_Hi  (Result_Hi),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .DivZero    (DivZero),
        .Illegal    (Illegal),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request and move to the sampling point after the accepting edge.
    task automatic step(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALU_Control = op;
        input_A     = a;
        input_B     = b;
        start       = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ALU_Control = 4'd0;
        input_A = '0;
        input_B = '0;
        repeat (2) @(negedge clk);

        chk("rst_result", 32'(Result), 32'h0);
        chk("rst_hi",     32'(Result_Hi), 32'h0);
        chk("rst_flags",  32'({Zero, Overflow, DivZero, Illegal, busy, done}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops
        step(4'd0, 16'd10, 16'd20);
        chk("add_done", 32'(done), 32'h1);
        chk("add_res",  32'(Result), 32'd30);
        chk("add_zero", 32'(Zero), 32'h0);
        chk("add_ovf",  32'(Overflow), 32'h0);
        chk("add_busy", 32'(busy), 32'h0);
        step(4'd1, 16'd10, 16'd20);
        chk("sub_done", 32'(done), 32'h1);
        chk("sub_res",  32'(Result), 32'hFFF6);
        chk("sub_ovf",  32'(Overflow), 32'h0);
        step(4'd0, 16'h7FFF, 16'h0001);
        chk("addov_res", 32'(Result), 32'h8000);
        chk("addov_ovf", 32'(Overflow), 32'h1);
        step(4'd1, 16'd5, 16'd5);
        chk("sub0_res",  32'(Result), 32'h0);
        chk("sub0_zero", 32'(Zero), 32'h1);
        chk("sub0_ovf",  32'(Overflow), 32'h0);
        step(4'd7, 16'd10, 16'd20);
        chk("slt1_res",  32'(Result), 32'h1);
        chk("slt1_done", 32'(done), 32'h1);
        step(4'd7, 16'hFFFF, 16'h0001);
        chk("slt2_res",  32'(Result), 32'h1);
        step(4'd5, 16'd6, 16'd2);
        chk("and_res",   32'(Result), 32'h2);
        step(4'd4, 16'd0, 16'd0);
        chk("nor_res",   32'(Result), 32'hFFFF);
        chk("nor_zero",  32'(Zero), 32'h0);
        step(4'd2, 16'h00F0, 16'h0F00);
        chk("or_res",    32'(Result), 32'h0FF0);
        step(4'd3, 16'hFF00, 16'h0FF0);
        chk("xor_res",   32'(Result), 32'hF0F0);
        step(4'd6, 16'h0003, 16'h0014);
        chk("sll_res",   32'(Result), 32'h0030);
        step(4'd1, 16'h8000, 16'h0001);
        chk("subov_res", 32'(Result), 32'h7FFF);
        chk("subov_ovf", 32'(Overflow), 32'h1);
        chk("subov_done", 32'(done), 32'h1);
        start = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_hold", 32'(Result), 32'h7FFF);

        // Illegal opcode
        step(4'd12, 16'd5, 16'd5);
        start = 1'b0;
        chk("ill_done", 32'(done), 32'h1);
        chk("ill_res",  32'(Result), 32'h0);
        chk("ill_hi",   32'(Result_Hi), 32'h0);
        chk("ill_zero", 32'(Zero), 32'h1);
        chk("ill_flag", 32'(Illegal), 32'h1);
        @(negedge clk);

        // MULU 300*500 = 0x249F0, with an ignored start mid-op
        step(4'd8, 16'd300, 16'd500);
        start = 1'b0;
        chk("mul_busy0", 32'(busy), 32'h1);
        chk("mul_done0", 32'(done), 32'h0);
        repeat (3) @(negedge clk);
        step(4'd0, 16'd1, 16'd1);
        start = 1'b0;
        input_A = 16'hABCD;
        input_B = 16'h1234;
        ALU_Control = 4'd9;
        chk("mul_ign_done", 32'(done), 32'h0);
        chk("mul_ign_busy", 32'(busy), 32'h1);
        // now after E4; E5..E15 still busy
        n_done = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("mul_busy15", 32'(busy), 32'h1);
        chk("mul_early_done", 32'(n_done), 32'h0);
        @(negedge clk);
        chk("mul_done",  32'(done), 32'h1);
        chk("mul_busy",  32'(busy), 32'h0);
        chk("mul_lo",    32'(Result), 32'h49F0);
        chk("mul_hi",    32'(Result_Hi), 32'h0002);
        chk("mul_ill",   32'(Illegal), 32'h0);
        chk("mul_zero",  32'(Zero), 32'h0);
        @(negedge clk);
        chk("mul_nodup", 32'(done), 32'h0);
        chk("mul_hold",  32'(Result), 32'h49F0);

        // DIVU 100/7
        step(4'd9, 16'd100, 16'd7);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("div_done15", 32'(done), 32'h0);
        @(negedge clk);
        chk("div_done", 32'(done), 32'h1);
        chk("div_q",    32'(Result), 32'd14);
        chk("div_r",    32'(Result_Hi), 32'd2);
        chk("div_dz",   32'(DivZero), 32'h0);

        // DIVU by zero, issued in the done cycle of the previous DIVU
        step(4'd9, 16'd100, 16'd0);
        start = 1'b0;
        repeat (15) @(negedge clk);
        @(negedge clk);
        chk("dz_done", 32'(done), 32'h1);
        chk("dz_q",    32'(Result), 32'hFFFF);
        chk("dz_r",    32'(Result_Hi), 32'd100);
        chk("dz_flag", 32'(DivZero), 32'h1);

        // Reset in the middle of a MULU
        step(4'd8, 16'd300, 16'd500);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_res",   32'(Result), 32'h0);
        chk("mrst_hi",    32'(Result_Hi), 32'h0);
        chk("mrst_flags", 32'({Zero, Overflow, DivZero, Illegal, busy, done}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("mrst_no_done", 32'(n_done), 32'h0);
        chk("mrst_busy",    32'(busy), 32'h0);
        step(4'd0, 16'd1, 16'd1);
        start = 1'b0;
        chk("post_add_done", 32'(done), 32'h1);
        chk("post_add_res",  32'(Result), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
